rr_arb_mux: RTL and testbench

RR_ARB_MUX -- requirements
Module: rr_arb_mux

---
 rtl/rr_arb_mux_pkg.sv | 12 +
 rtl/rr_arbiter.sv | 44 ++++
 rtl/rr_arb_mux.sv | 139 +++++++++++++
 tb/tb_rr_arb_mux.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/rr_arb_mux_pkg.sv
// Shared defaults and mode encoding for the round-robin / fixed-select arbiter mux.
package rr_arb_mux_pkg;

  localparam int N_CH_DEF = 4;
  localparam int W_DEF    = 2;

  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } mode_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin search: first valid channel starting at ptr, wrapping to 0.
module rr_arbiter #(
  parameter int N_CH = 4,
  parameter int SW   = $clog2(N_CH)
) (
  input  logic [N_CH-1:0] valid,
  input  logic [SW-1:0]   ptr,
  output logic [N_CH-1:0] grant,
  output logic [SW-1:0]   idx,
  output logic            found
);

  int              base_v;
  int              cand_v;
  logic [SW-1:0]   cand_idx_s;

  // Walk the channels in priority order ptr, ptr+1, ... and keep the first hit.
  always_comb begin
    grant      = '0;
    idx        = '0;
    found      = 1'b0;
    cand_v     = 0;
    cand_idx_s = '0;
    // An out-of-range pointer can only arise for non-power-of-two N_CH; treat it as 0.
    base_v     = (int'(ptr) < N_CH) ? int'(ptr) : 0;
    for (int i = 0; i < N_CH; i++) begin
      cand_v = base_v + i;
      if (cand_v >= N_CH) begin
        cand_v = cand_v - N_CH;
      end else begin
        cand_v = cand_v;
      end
      cand_idx_s = cand_v[SW-1:0];
      if (!found && valid[cand_idx_s]) begin
        grant[cand_idx_s] = 1'b1;
        idx               = cand_idx_s;
        found             = 1'b1;
      end else begin
        found = found;
      end
    end
  end

endmodule

// File: rtl/rr_arb_mux.sv
// N-channel valid/ready mux with fixed-select or round-robin grant into a single
// registered output stage that sustains one beat per cycle.
module rr_arb_mux
  import rr_arb_mux_pkg::*;
#(
  parameter int N_CH = N_CH_DEF,
  parameter int W    = W_DEF,
  parameter int SW   = $clog2(N_CH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            mode,
  input  logic [SW-1:0]   sel,
  input  logic [N_CH*W-1:0] in_data,
  input  logic [N_CH-1:0] in_valid,
  output logic [N_CH-1:0] in_ready,
  output logic [W-1:0]    out_data,
  output logic [SW-1:0]   out_ch,
  output logic            out_valid,
  input  logic            out_ready
);

  logic [SW-1:0]   ptr_r;
  logic [W-1:0]    out_data_r;
  logic [SW-1:0]   out_ch_r;
  logic            out_valid_r;

  mode_e           mode_s;
  logic [N_CH-1:0] rr_grant_s;
  logic [SW-1:0]   rr_idx_s;
  logic            rr_found_s;
  logic [N_CH-1:0] fix_grant_s;
  logic [N_CH-1:0] win_grant_s;
  logic [SW-1:0]   win_idx_s;
  logic [W-1:0]    win_data_s;
  logic [SW-1:0]   ptr_nxt_s;
  logic            free_s;
  logic            grant_ok_s;
  logic            xfer_s;

  assign mode_s = mode_e'(mode);

  rr_arbiter #(
    .N_CH (N_CH),
    .SW   (SW)
  ) u_rr_arbiter (
    .valid (in_valid),
    .ptr   (ptr_r),
    .grant (rr_grant_s),
    .idx   (rr_idx_s),
    .found (rr_found_s)
  );

  // Fixed-select winner; an out-of-range sel matches no channel and so grants nothing.
  always_comb begin
    fix_grant_s = '0;
    for (int i = 0; i < N_CH; i++) begin
      if ((sel == SW'(i)) && in_valid[i]) begin
        fix_grant_s[i] = 1'b1;
      end else begin
        fix_grant_s[i] = 1'b0;
      end
    end
  end

  // Choose the winner for the current mode.
  always_comb begin
    win_grant_s = '0;
    win_idx_s   = '0;
    case (mode_s)
      MODE_RR: begin
        win_grant_s = rr_found_s ? rr_grant_s : '0;
        win_idx_s   = rr_idx_s;
      end
      MODE_FIXED: begin
        win_grant_s = fix_grant_s;
        win_idx_s   = sel;
      end
      default: begin
        win_grant_s = '0;
        win_idx_s   = '0;
      end
    endcase
  end

  // One-hot AND-OR data select keyed by the winning grant.
  always_comb begin
    win_data_s = '0;
    for (int i = 0; i < N_CH; i++) begin
      win_data_s = win_data_s | (in_data[i*W +: W] & {W{win_grant_s[i]}});
    end
  end

  // Pointer advance past the winner with wrap at the last channel.
  always_comb begin
    if (win_idx_s == SW'(N_CH - 1)) begin
      ptr_nxt_s = '0;
    end else begin
      ptr_nxt_s = win_idx_s + SW'(1);
    end
  end

  assign free_s     = ~out_valid_r | out_ready;
  assign grant_ok_s = rst_n & en & free_s;
  assign in_ready   = win_grant_s & {N_CH{grant_ok_s}};
  assign xfer_s     = |in_ready;

  // Output stage: load on an input transfer, empty when freed without one, hold while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_ch_r    <= '0;
    end else if (free_s) begin
      if (xfer_s) begin
        out_valid_r <= 1'b1;
        out_data_r  <= win_data_s;
        out_ch_r    <= win_idx_s;
      end else begin
        out_valid_r <= 1'b0;
      end
    end
  end

  // Round-robin pointer only moves on a round-robin transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r <= '0;
    end else if (xfer_s && (mode_s == MODE_RR)) begin
      ptr_r <= ptr_nxt_s;
    end
  end

  assign out_data  = out_data_r;
  assign out_ch    = out_ch_r;
  assign out_valid = out_valid_r;

endmodule

// File: tb/tb_rr_arb_mux.sv
// Directed checks of rr_arb_mux (N_CH=4, W=2) with hand-computed expected values.
module tb_rr_arb_mux;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       mode;
  logic [1:0] sel;
  logic [7:0] in_data;
  logic [3:0] in_valid;
  logic [3:0] in_ready;
  logic [1:0] out_data;
  logic [1:0] out_ch;
  logic       out_valid;
  logic       out_ready;

  int vectors;
  int miscompares;

  rr_arb_mux #(.N_CH(4), .W(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .mode      (mode),
    .sel       (sel),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [1:0] d, input logic [1:0] c);
    chk({tag, ".valid"}, 32'(out_valid), 32'(v));
    chk({tag, ".data"},  32'(out_data),  32'(d));
    chk({tag, ".ch"},    32'(out_ch),    32'(c));
  endtask

  // Advance past the next rising edge; outputs are sampled 2 time units after it.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n     = 1'b0;
    en        = 1'b1;
    mode      = 1'b0;
    sel       = 2'd0;
    in_data   = 8'b11_10_01_00;
    in_valid  = 4'b1111;
    out_ready = 1'b1;

    // Reset state, with requests present
    #1;
    chk_out("reset", 1'b0, 2'd0, 2'd0);
    chk("reset.in_ready", 32'(in_ready), 32'h0);
    #11;
    rst_n = 1'b1;
    tick();

    // Fixed select of channel 2
    mode = 1'b0; sel = 2'd2;
    #1 chk("fixed.in_ready", 32'(in_ready), 32'b0100);
    tick();
    chk_out("fixed.out", 1'b1, 2'b10, 2'd2);

    // Round-robin from ptr 0 (fixed cycles must not have moved it)
    mode = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1 chk($sformatf("rr%0d.in_ready", k), 32'(in_ready), 32'(4'b0001 << (k % 4)));
      tick();
      chk_out($sformatf("rr%0d.out", k), 1'b1, 2'(k % 4), 2'(k % 4));
    end

    // Fixed mode, selected channel idle: register empties, data/ch hold
    mode = 1'b0; sel = 2'd1; in_valid = 4'b1101;
    #1 chk("fixidle.in_ready", 32'(in_ready), 32'h0);
    tick();
    chk_out("fixidle.out", 1'b0, 2'd0, 2'd0);

    // Drive ptr to 3 via channel 2, then wrap-around search picks channel 1
    in_data = 8'b01_00_11_10;
    mode = 1'b1; in_valid = 4'b0100;
    #1 chk("toptr3.in_ready", 32'(in_ready), 32'b0100);
    tick();
    chk_out("toptr3.out", 1'b1, 2'd0, 2'd2);
    in_valid = 4'b0110;
    #1 chk("wrap.in_ready", 32'(in_ready), 32'b0010);
    tick();
    chk_out("wrap.out", 1'b1, 2'd3, 2'd1);
    #1 chk("ptr2.in_ready", 32'(in_ready), 32'b0100);

    // Stall for 3 cycles: nothing granted, beat held
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1 chk($sformatf("stall%0d.in_ready", k), 32'(in_ready), 32'h0);
      tick();
      chk_out($sformatf("stall%0d.out", k), 1'b1, 2'd3, 2'd1);
    end

    // Release: drain and new grant in the same cycle (ptr=2, search 2,3,0)
    out_ready = 1'b1; in_valid = 4'b0001;
    #1 chk("drain.in_ready", 32'(in_ready), 32'b0001);
    tick();
    chk_out("drain.out", 1'b1, 2'd2, 2'd0);

    // en=0: pending beat drains, then no grants
    en = 1'b0; in_valid = 4'b1111;
    #1 chk("en0.in_ready", 32'(in_ready), 32'h0);
    tick();
    chk("en0a.valid", 32'(out_valid), 32'h0);
    tick();
    chk("en0b.valid", 32'(out_valid), 32'h0);
    chk("en0b.in_ready", 32'(in_ready), 32'h0);
    en = 1'b1;
    #1 chk("en1.in_ready", 32'(in_ready), 32'b0010);
    tick();
    chk_out("en1.out", 1'b1, 2'd3, 2'd1);

    // Reset asserted mid-stall clears outputs at once
    out_ready = 1'b0;
    tick();
    chk_out("prestall.out", 1'b1, 2'd3, 2'd1);
    #1 rst_n = 1'b0;
    #1;
    chk_out("midrst.out", 1'b0, 2'd0, 2'd0);
    chk("midrst.in_ready", 32'(in_ready), 32'h0);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;

    // After release the search starts again from channel 0
    #1 chk("postrst.in_ready", 32'(in_ready), 32'b0001);
    tick();
    chk_out("postrst.out", 1'b1, 2'd2, 2'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
